// File: rtl/seq_divider_pkg.sv
// Shared types and widths for the sequential restoring divider.
// SEQ_DIVIDER_DIV_ZERO_EN (see seq_divider.sv) enables the zero-divisor fast path.
package seq_divider_pkg;

  localparam int unsigned DefaultN = 4;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  // Step counter must reach 2N.
  function automatic int unsigned cnt_width(int unsigned n);
    return $clog2(2 * n + 1);
  endfunction

  localparam int unsigned DefaultCntW = cnt_width(DefaultN);

endpackage

// File: rtl/seq_divider_if.sv
// Start/done handshake and operand/result bundle for seq_divider.
interface seq_divider_if
  import seq_divider_pkg::*;
#(
  parameter int unsigned N = DefaultN
);

  logic             start;
  logic [2*N-1:0]   dividend;
  logic [N-1:0]     divisor;
  logic             busy;
  logic             done;
  logic [2*N-1:0]   quotient;
  logic [N-1:0]     remainder;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );

endinterface

// File: rtl/seq_divider_div_step.sv
// One combinational restoring-division step: shift in a dividend bit, trial-subtract the divisor.
module seq_divider_div_step
  import seq_divider_pkg::*;
#(
  parameter int unsigned N = DefaultN
) (
  input  logic [N:0]   r_i,
  input  logic         bit_i,
  input  logic [N-1:0] divisor_i,
  output logic [N:0]   r_o,
  output logic         q_o
);

  logic [N:0] t;
  // R < divisor keeps the top bit clear, so only the low N bits feed the shift.
  logic       unused_r_msb;

  assign unused_r_msb = r_i[N];

  always_comb begin
    t = {r_i[N-1:0], bit_i};
    if (t >= {1'b0, divisor_i}) begin
      r_o = t - {1'b0, divisor_i};
      q_o = 1'b1;
    end else begin
      r_o = t;
      q_o = 1'b0;
    end
  end

endmodule

// File: rtl/seq_divider.sv
// Sequential restoring divider: 2N-bit dividend / N-bit divisor, one quotient bit per clock.
// Define SEQ_DIVIDER_DIV_ZERO_EN to short-circuit a zero divisor and raise div_by_zero.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int unsigned N = DefaultN
) (
  input logic          clk,
  input logic          rst,
  seq_divider_if.slave bus
);

  localparam int unsigned W2   = 2 * N;
  localparam int unsigned CntW = cnt_width(N);

  state_e          state_q, state_d;
  logic [W2-1:0]   dvd_q, dvd_d;
  logic [W2-1:0]   qacc_q, qacc_d;
  logic [W2-1:0]   quot_q, quot_d;
  logic [N-1:0]    dvs_q, dvs_d;
  logic [N-1:0]    rem_q, rem_d;
  logic [N:0]      r_q, r_d, r_step;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            q_bit;
  logic            last_step;
  logic            zero_div;

  seq_divider_div_step #(
    .N(N)
  ) u_step (
    .r_i      (r_q),
    .bit_i    (dvd_q[W2-1]),
    .divisor_i(dvs_q),
    .r_o      (r_step),
    .q_o      (q_bit)
  );

  assign last_step = (cnt_q == CntW'(W2 - 1));

`ifdef SEQ_DIVIDER_DIV_ZERO_EN
  assign zero_div = (bus.divisor == '0);
`else
  assign zero_div = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (bus.start) state_d = zero_div ? StDone : StRun;
      StRun:   if (last_step) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    bus.busy = (state_q == StRun);
    bus.done = (state_q == StDone);
  end

  always_comb begin
    dvd_d  = dvd_q;
    dvs_d  = dvs_q;
    r_d    = r_q;
    qacc_d = qacc_q;
    cnt_d  = cnt_q;
    quot_d = quot_q;
    rem_d  = rem_q;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          dvd_d  = bus.dividend;
          dvs_d  = bus.divisor;
          r_d    = '0;
          qacc_d = '0;
          cnt_d  = '0;
`ifdef SEQ_DIVIDER_DIV_ZERO_EN
          if (zero_div) begin
            quot_d = '1;
            rem_d  = bus.dividend[N-1:0];
          end
`endif
        end
      end
      StRun: begin
        dvd_d  = {dvd_q[W2-2:0], 1'b0};
        r_d    = r_step;
        qacc_d = {qacc_q[W2-2:0], q_bit};
        cnt_d  = cnt_q + 1'b1;
        // Results are published only on the edge into StDone.
        if (last_step) begin
          quot_d = {qacc_q[W2-2:0], q_bit};
          rem_d  = r_step[N-1:0];
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dvd_q  <= '0;
      dvs_q  <= '0;
      r_q    <= '0;
      qacc_q <= '0;
      cnt_q  <= '0;
      quot_q <= '0;
      rem_q  <= '0;
    end else begin
      dvd_q  <= dvd_d;
      dvs_q  <= dvs_d;
      r_q    <= r_d;
      qacc_q <= qacc_d;
      cnt_q  <= cnt_d;
      quot_q <= quot_d;
      rem_q  <= rem_d;
    end
  end

  assign bus.quotient  = quot_q;
  assign bus.remainder = rem_q;

`ifdef SEQ_DIVIDER_DIV_ZERO_EN
  logic dbz_q, dbz_d;

  // Sticky until the next completion: set by a zero-divisor accept, cleared by a normal finish.
  always_comb begin
    dbz_d = dbz_q;
    if (state_q == StIdle && bus.start && zero_div) begin
      dbz_d = 1'b1;
    end else if (state_q == StRun && last_step) begin
      dbz_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dbz_q <= 1'b0;
    end else begin
      dbz_q <= dbz_d;
    end
  end

  assign bus.div_by_zero = dbz_q;
`else
  assign bus.div_by_zero = 1'b0;
`endif

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: stimulus pushes model results, a negedge monitor checks them.
module tb_seq_divider;

  localparam int unsigned N  = 4;
  localparam int unsigned W2 = 2 * N;
`ifdef SEQ_DIVIDER_DIV_ZERO_EN
  localparam bit Dz = 1'b1;
`else
  localparam bit Dz = 1'b0;
`endif

  typedef struct {
    int unsigned q;
    int unsigned r;
    int unsigned z;
    int          lat;   // posedges from accepting edge to the edge that raises done
    int          busy;  // cycles busy is expected high
    int          acc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  exp_t exp_q[$];

  seq_divider_if #(.N(N)) dif ();

  seq_divider #(.N(N)) dut (
    .clk(clk),
    .rst(rst),
    .bus(dif)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic exp_t model(int unsigned a, int unsigned b, int acc);
    exp_t e;
    e.acc = acc;
    if (b == 0) begin
      e.q    = (1 << W2) - 1;
      e.r    = a % (1 << N);
      e.z    = Dz;
      e.lat  = Dz ? 0 : W2;
      e.busy = Dz ? 0 : W2;
    end else begin
      e.q    = a / b;
      e.r    = a % b;
      e.z    = 0;
      e.lat  = W2;
      e.busy = W2;
    end
    return e;
  endfunction

  // Monitor: all sampling on the falling edge, inputs change just after the rising edge.
  int          busy_cnt = 0;
  bit          prev_done = 1'b0;
  bit          armed = 1'b0;
  int unsigned held_q = 0, held_r = 0, held_z = 0;

  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (dif.done) begin
      if (prev_done) check("done_single_pulse", 32'd1, 32'd0);
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("quotient", 32'(dif.quotient), e.q);
        check("remainder", 32'(dif.remainder), e.r);
        check("div_by_zero", 32'(dif.div_by_zero), e.z);
        check("latency", 32'(cyc - e.acc - 1), 32'(e.lat));
        check("busy_cycles", 32'(busy_cnt), 32'(e.busy));
        held_q = e.q;
        held_r = e.r;
        held_z = e.z;
      end
      busy_cnt = 0;
    end else if (armed) begin
      check("hold_quotient", 32'(dif.quotient), held_q);
      check("hold_remainder", 32'(dif.remainder), held_r);
      check("hold_div_by_zero", 32'(dif.div_by_zero), held_z);
    end
    if (dif.busy) busy_cnt++;
    prev_done = dif.done;
    if (rst) begin
      held_q   = 0;
      held_r   = 0;
      held_z   = 0;
      busy_cnt = 0;
      armed    = 1'b1;
    end
  end

  task automatic wait_idle();
    for (int i = 0; i < 100; i++) begin
      if (!dif.busy && !dif.done) return;
      @(posedge clk);
      #1;
    end
    check("idle_timeout", 32'd1, 32'd0);
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic issue(input int unsigned a, input int unsigned b);
    wait_idle();
    dif.start    = 1'b1;
    dif.dividend = W2'(a);
    dif.divisor  = N'(b);
    @(posedge clk);
    exp_q.push_back(model(a, b, cyc));
    #1;
    dif.start = 1'b0;
  endtask

  initial begin
    int unsigned a, b;
    dif.start    = 1'b0;
    dif.dividend = '0;
    dif.divisor  = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("reset_busy", 32'(dif.busy), 32'd0);
    check("reset_done", 32'(dif.done), 32'd0);
    check("reset_quotient", 32'(dif.quotient), 32'd0);
    check("reset_remainder", 32'(dif.remainder), 32'd0);
    check("reset_div_by_zero", 32'(dif.div_by_zero), 32'd0);
    @(posedge clk);
    #1;

    issue(100, 7);
    issue(255, 1);
    issue(225, 15);
    issue(0, 5);
    issue(8'hA5, 0);
    issue(8'hA5, 3);

    // A start pulse mid-run must be ignored.
    issue(100, 7);
    repeat (2) @(posedge clk);
    #1;
    dif.start    = 1'b1;
    dif.dividend = 8'd50;
    dif.divisor  = 4'd3;
    @(posedge clk);
    #1;
    dif.start = 1'b0;

    // Reset mid-run aborts with no done; then a fresh run completes.
    issue(200, 9);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("abort_busy", 32'(dif.busy), 32'd0);
    check("abort_done", 32'(dif.done), 32'd0);
    check("abort_quotient", 32'(dif.quotient), 32'd0);
    check("abort_remainder", 32'(dif.remainder), 32'd0);
    @(posedge clk);
    #1;
    issue(200, 9);

    // start held high: accepts every 2N+2 edges.
    wait_idle();
    dif.start    = 1'b1;
    dif.dividend = 8'd37;
    dif.divisor  = 4'd5;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      exp_q.push_back(model(dif.dividend, dif.divisor, cyc));
      #1;
      if (k == 3) begin
        dif.start = 1'b0;
      end else begin
        dif.dividend = W2'($urandom_range(0, 255));
        dif.divisor  = N'($urandom_range(1, 15));
        repeat (W2 + 1) @(posedge clk);
      end
    end

    for (int i = 0; i < 40; i++) begin
      a = $urandom_range(0, 255);
      b = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 15);
      issue(a, b);
    end

    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(posedge clk);
    @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
